// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, state/op encodings and decode helpers for the RV32I control FSM
//   OPC_* / F3_* / F7_*  opcode and funct fields of the supported instructions
//   SEL_*                operand-select encoding driven on num1_CS / num2_CS
//   ALU_ADD / ALU_SUB    ALU_mode encoding
//   state_t, op_t, imm_t controller state, decoded operation, immediate format
package cpu_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [2:0] F3_ADD     = 3'b000;
   localparam logic [6:0] F7_ADD     = 7'b0000000;
   localparam logic [6:0] F7_SUB     = 7'b0100000;

   localparam logic [1:0] SEL_REG0 = 2'd0;
   localparam logic [1:0] SEL_IM   = 2'd1;
   localparam logic [1:0] SEL_PC   = 2'd2;
   localparam logic [1:0] SEL_REG1 = 2'd3;

   localparam logic ALU_ADD = 1'b1;
   localparam logic ALU_SUB = 1'b0;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
   typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_ADDI, OP_AUIPC, OP_JAL, OP_ILL} op_t;
   typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_U, IMM_J} imm_t;

   typedef struct packed {
      logic [1:0] num1;
      logic [1:0] num2;
      logic       mode;
   } exec_ctrl_t;

   function automatic op_t decode_op(input logic [31:0] w);
      op_t op;
      op = OP_ILL;
      case (w[6:0])
         OPC_OP:     if (w[14:12] == F3_ADD)
                        op = w[31:25] == F7_ADD ? OP_ADD : w[31:25] == F7_SUB ? OP_SUB : OP_ILL;
         OPC_OP_IMM: if (w[14:12] == F3_ADD) op = OP_ADDI;
         OPC_AUIPC:  op = OP_AUIPC;
         OPC_JAL:    op = OP_JAL;
         default:    op = OP_ILL;
      endcase
      return op;
   endfunction

   function automatic imm_t imm_kind(input op_t op);
      return op == OP_ADDI  ? IMM_I :
             op == OP_AUIPC ? IMM_U :
             op == OP_JAL   ? IMM_J : IMM_NONE;
   endfunction

   function automatic exec_ctrl_t exec_ctrl(input op_t op);
      exec_ctrl_t c;
      case (op)
         OP_ADD:   c = '{SEL_REG0, SEL_REG1, ALU_ADD};
         OP_SUB:   c = '{SEL_REG0, SEL_REG1, ALU_SUB};
         OP_ADDI:  c = '{SEL_REG0, SEL_IM,   ALU_ADD};
         OP_AUIPC: c = '{SEL_PC,   SEL_IM,   ALU_ADD};
         OP_JAL:   c = '{SEL_PC,   SEL_IM,   ALU_ADD};
         default:  c = '{SEL_REG0, SEL_REG0, ALU_ADD};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_imm_gen.sv
// imm_gen: combinational I/U/J immediate extraction with sign extension
//   kind     in   2   immediate format (imm_t: NONE/I/U/J)
//   instr_hi in  20   instruction bits [31:12] (bit 19 here is instruction bit 31)
//   imm      out 32   sign-extended immediate, 0 for NONE
module imm_gen
   import cpu_pkg::*;
(
   input  logic [1:0]  kind,
   input  logic [19:0] instr_hi,
   output logic [31:0] imm
);

   always_comb
      imm = kind == IMM_I ? {{20{instr_hi[19]}}, instr_hi[19:8]} :
            kind == IMM_U ? {instr_hi, 12'b0} :
            kind == IMM_J ? {{12{instr_hi[19]}}, instr_hi[7:0], instr_hi[8], instr_hi[18:9], 1'b0} :
            32'b0;

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/WB controller for ADD, SUB, ADDI, AUIPC, JAL; owns the PC
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req/addr/ack/rdata   instruction fetch handshake (addr = PC)
//   rs1_addr, rs2_addr        register-file read addresses
//   ALU_mode, num1_CS, num2_CS ALU control, valid in EXEC only
//   IM_out, PC_out            immediate and PC fed to the ALU operand muxes
//   ALU_result                combinational ALU output, sampled at the end of EXEC
//   rd_we/rd_addr/rd_wdata    register-file write port, pulsed in WB
//   illegal                   sticky fault flag, set on entry to HALT
module cpu_ctrl_fsm
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output logic        ALU_mode,
   output logic [1:0]  num1_CS,
   output logic [1:0]  num2_CS,
   output logic [31:0] IM_out,
   output logic [31:0] PC_out,
   input  logic [31:0] ALU_result,
   output logic        rd_we,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_wdata,
   output logic        illegal
);

   state_t      state, state_d;
   op_t         op_q, op_dec;
   logic [31:0] pc, ir, imm_q, alu_q, imm_dec, pc_plus4;
   logic [4:0]  rd_q, rs1_q, rs2_q;
   logic [1:0]  kind_dec;
   exec_ctrl_t  ctrl;

   assign op_dec   = decode_op(ir);
   assign kind_dec = imm_kind(op_dec);
   assign pc_plus4 = pc + 32'd4;
   assign ctrl     = exec_ctrl(op_q);

   imm_gen u_imm_gen (
      .kind     (kind_dec),
      .instr_hi (ir[31:12]),
      .imm      (imm_dec)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         ir      <= '0;
         op_q    <= OP_ILL;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         illegal <= 1'b0;
      end else begin
         state <= state_d;
         if (state == S_FETCH && imem_ack) ir <= imem_rdata;
         if (state == S_DECODE) begin
            op_q  <= op_dec;
            rd_q  <= ir[11:7];
            rs1_q <= ir[19:15];
            rs2_q <= ir[24:20];
            imm_q <= imm_dec;
         end
         if (state == S_EXEC) alu_q <= ALU_result;
         if (state == S_WB) pc <= op_q == OP_JAL ? alu_q : pc_plus4;
         if (state_d == S_HALT) illegal <= 1'b1;
      end

   // A misaligned JAL target is caught from the live ALU result in EXEC so WB
   // (and with it the link write and the PC update) never happens.
   always_comb begin
      state_d = state;
      case (state)
         S_FETCH:  state_d = imem_ack ? S_DECODE : S_FETCH;
         S_DECODE: state_d = op_dec == OP_ILL ? S_HALT : S_EXEC;
         S_EXEC:   state_d = op_q == OP_JAL && ALU_result[1:0] != 2'b00 ? S_HALT : S_WB;
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      imem_req  = state == S_FETCH;
      imem_addr = pc;
      PC_out    = pc;
      IM_out    = imm_q;
      rs1_addr  = rs1_q;
      rs2_addr  = rs2_q;
      num1_CS   = state == S_EXEC ? ctrl.num1 : SEL_REG0;
      num2_CS   = state == S_EXEC ? ctrl.num2 : SEL_REG0;
      ALU_mode  = state == S_EXEC ? ctrl.mode : ALU_ADD;
      rd_we     = state == S_WB && rd_q != 5'd0;
      rd_addr   = rd_q;
      rd_wdata  = op_q == OP_JAL ? pc_plus4 : alu_q;
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed spec cases plus randomized instruction stream checked against an instruction-level model
module tb_cpu_ctrl_fsm;

   localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_AUIPC = 3, K_JAL = 4, K_BAD = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        ALU_mode, rd_we, illegal;
   logic [1:0]  num1_CS, num2_CS;
   logic [31:0] IM_out, PC_out, ALU_result, rd_wdata;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] pc_m;
   logic [31:0] bad_words [4] = '{32'h0000_0000, 32'h0200_00B3, 32'h0000_1093, 32'h0000_0063};

   cpu_ctrl_fsm #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .ALU_mode   (ALU_mode),
      .num1_CS    (num1_CS),
      .num2_CS    (num2_CS),
      .IM_out     (IM_out),
      .PC_out     (PC_out),
      .ALU_result (ALU_result),
      .rd_we      (rd_we),
      .rd_addr    (rd_addr),
      .rd_wdata   (rd_wdata),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Instruction encoder: builds the word from the fields the model chose.
   function automatic logic [31:0] enc(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [31:0] imm);
      case (k)
         K_ADD:   return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
         K_SUB:   return {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
         K_ADDI:  return {imm[11:0], rs1, 3'b000, rd, 7'h13};
         K_AUIPC: return {imm[31:12], rd, 7'h17};
         K_JAL:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
         default: return 32'h0000_0000;
      endcase
   endfunction

   // {num1_CS, num2_CS, ALU_mode} required during EXEC
   function automatic logic [4:0] exp_ctrl(input int k);
      case (k)
         K_ADD:   return 5'b00_11_1;
         K_SUB:   return 5'b00_11_0;
         K_ADDI:  return 5'b00_01_1;
         default: return 5'b10_01_1;
      endcase
   endfunction

   // Called at a negedge; checks the asynchronous reset values before any clock edge.
   task automatic do_reset();
      rst = 1'b1;
      imem_ack = 1'b0;
      ALU_result = '0;
      #1;
      check("rst_req", imem_req, 1);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_we", rd_we, 0);
      check("rst_illegal", illegal, 0);
      check("rst_ctrl", {num1_CS, num2_CS, ALU_mode}, 5'b00_00_1);
      check("rst_imm", IM_out, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      pc_m = 32'h0;
   endtask

   // One instruction, cycle by cycle; entered so the next negedge is a FETCH cycle.
   task automatic run_instr(input logic [31:0] word, input int k, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                            input int delay, input logic [31:0] alu, input bit spurious,
                            input bit rst_exec);
      logic jal_bad;
      for (int c = 0; c <= delay; c++) begin
         @(negedge clk);
         check("fetch_req", imem_req, 1);
         check("fetch_addr", imem_addr, pc_m);
         check("fetch_we", rd_we, 0);
         imem_ack = c == delay;
         imem_rdata = c == delay ? word : $urandom;
      end
      @(negedge clk);
      imem_ack = 1'b0;
      check("dec_req", imem_req, 0);
      check("dec_ctrl", {num1_CS, num2_CS, ALU_mode}, 5'b00_00_1);
      @(negedge clk);
      if (k == K_BAD) begin
         for (int c = 0; c < 3; c++) begin
            check("ill_flag", illegal, 1);
            check("ill_req", imem_req, 0);
            check("ill_we", rd_we, 0);
            @(negedge clk);
         end
         return;
      end
      check("exec_illegal", illegal, 0);
      check("exec_ctrl", {num1_CS, num2_CS, ALU_mode}, exp_ctrl(k));
      check("exec_pc", PC_out, pc_m);
      if (k != K_AUIPC && k != K_JAL) check("exec_rs1", rs1_addr, rs1);
      if (k == K_ADD || k == K_SUB) check("exec_rs2", rs2_addr, rs2);
      if (k >= K_ADDI) check("exec_imm", IM_out, imm);
      if (rst_exec) begin
         do_reset();
         return;
      end
      ALU_result = alu;
      imem_ack = spurious;
      @(negedge clk);
      imem_ack = 1'b0;
      ALU_result = $urandom;
      #1;
      jal_bad = k == K_JAL && alu[1:0] != 2'b00;
      if (jal_bad) begin
         for (int c = 0; c < 3; c++) begin
            check("jal_flag", illegal, 1);
            check("jal_req", imem_req, 0);
            check("jal_we", rd_we, 0);
            check("jal_pc", PC_out, pc_m);
            @(negedge clk);
         end
         return;
      end
      check("wb_we", rd_we, rd != 5'd0);
      check("wb_rd", rd_addr, rd);
      if (rd != 5'd0) check("wb_data", rd_wdata, k == K_JAL ? pc_m + 32'd4 : alu);
      pc_m = k == K_JAL ? alu : pc_m + 32'd4;
   endtask

   initial begin
      int          k, delay;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm, alu, word;
      rst = 1'b1;
      imem_ack = 1'b0;
      imem_rdata = '0;
      ALU_result = '0;
      @(negedge clk);
      do_reset();
      run_instr(32'h0050_0093, K_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 0, 32'd5, 1'b0, 1'b0);
      run_instr(32'h4020_81B3, K_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 0, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_instr(enc(K_ADDI, 5'd0, 5'd7, 5'd0, 32'd9), K_ADDI, 5'd0, 5'd7, 5'd0, 32'd9, 3, 32'h1234, 1'b1, 1'b0);
      run_instr(enc(K_ADD, 5'd4, 5'd5, 5'd6, 32'd0), K_ADD, 5'd4, 5'd5, 5'd6, 32'd0, 1, 32'h55, 1'b0, 1'b0);
      run_instr(32'hFF9F_F0EF, K_JAL, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFF8, 0, 32'h0000_0008, 1'b0, 1'b0);
      run_instr(enc(K_JAL, 5'd2, 5'd0, 5'd0, 32'h0000_0100), K_JAL, 5'd2, 5'd0, 5'd0, 32'h0000_0100, 0,
                32'hFFFF_FFFC, 1'b0, 1'b0);
      run_instr(enc(K_ADDI, 5'd5, 5'd1, 5'd0, 32'hFFFF_FFFF), K_ADDI, 5'd5, 5'd1, 5'd0, 32'hFFFF_FFFF, 0,
                32'h7, 1'b0, 1'b0);
      run_instr(enc(K_AUIPC, 5'd8, 5'd0, 5'd0, 32'hABCD_E000), K_AUIPC, 5'd8, 5'd0, 5'd0, 32'hABCD_E000, 2,
                32'h9, 1'b1, 1'b0);
      run_instr(enc(K_JAL, 5'd1, 5'd0, 5'd0, 32'h0000_0010), K_JAL, 5'd1, 5'd0, 5'd0, 32'h0000_0010, 0,
                32'h0000_0016, 1'b0, 1'b0);
      do_reset();
      run_instr(32'h0000_0000, K_BAD, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0, 1'b0, 1'b0);
      do_reset();
      run_instr(32'h0050_0093, K_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 0, 32'd5, 1'b0, 1'b1);
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 15) == 0 ? K_BAD : int'($urandom_range(K_ADD, K_JAL));
         rd = 5'($urandom);
         rs1 = 5'($urandom);
         rs2 = 5'($urandom);
         delay = $urandom_range(0, 3);
         alu = $urandom;
         imm = 32'd0;
         if (k == K_ADDI) imm = 32'($urandom_range(0, 4095)) - 32'd2048;
         if (k == K_AUIPC) imm = $urandom & 32'hFFFF_F000;
         if (k == K_JAL) begin
            imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
            if ($urandom_range(0, 7) != 0) alu = alu & 32'hFFFF_FFFC;
         end
         word = k == K_BAD ? bad_words[$urandom_range(0, 3)] : enc(k, rd, rs1, rs2, imm);
         run_instr(word, k, rd, rs1, rs2, imm, delay, alu, 1'($urandom), 1'b0);
         if (k == K_BAD || (k == K_JAL && alu[1:0] != 2'b00)) do_reset();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
